// File: rtl/karat_product_accumulator_if.sv
// rtl/karat_product_accumulator_if.sv - product-in / frame-result-out handshake bundle
interface karat_product_accumulator_if #(
  parameter int PW    = 32,
  parameter int AW    = 40,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/karat_product_accumulator.sv
// rtl/karat_product_accumulator.sv - frame accumulator for the Karatsuba multiplier product stream
module karat_product_accumulator #(
  parameter int PW    = 32,
  parameter int AW    = 40,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  karat_product_accumulator_if.slave bus
);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [AW:0]      sum_ext;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             take;

  // One extra bit on the sum exposes the wrap so it can be made sticky.
  assign sum_ext  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign ovf_next = ovf | sum_ext[AW];

  // Ready is masked while reset is held so the multiplier never sees a phantom slot.
  assign bus.in_ready = rst_n & (state == ACC);
  assign take         = bus.in_valid & bus.in_ready;

  // Two-state frame FSM: accumulate beats, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACC;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (take) begin
            if (bus.in_last) begin
              // Publish the post-update totals and start the next frame clean.
              bus.out_sum   <= sum_ext[AW-1:0];
              bus.out_count <= cnt_next;
              bus.out_ovf   <= ovf_next;
              bus.out_valid <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
              ovf           <= 1'b0;
              state         <= DONE;
            end else begin
              acc <= sum_ext[AW-1:0];
              cnt <= cnt_next;
              ovf <= ovf_next;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_karat_product_accumulator.sv
// tb/tb_karat_product_accumulator.sv - randomized self-checking bench for karat_product_accumulator
module tb_karat_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_prod = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] frame_q[$];

  karat_product_accumulator_if #(.PW(32), .AW(40), .CNT_W(8)) bus40 ();
  karat_product_accumulator_if #(.PW(32), .AW(33), .CNT_W(8)) bus33 ();

  assign bus40.in_valid  = in_valid;
  assign bus40.in_prod   = in_prod;
  assign bus40.in_last   = in_last;
  assign bus40.out_ready = out_ready;
  assign bus33.in_valid  = in_valid;
  assign bus33.in_prod   = in_prod;
  assign bus33.in_last   = in_last;
  assign bus33.out_ready = out_ready;

  karat_product_accumulator #(.PW(32), .AW(40), .CNT_W(8)) dut40 (
    .clk(clk), .rst_n(rst_n), .bus(bus40)
  );
  karat_product_accumulator #(.PW(32), .AW(33), .CNT_W(8)) dut33 (
    .clk(clk), .rst_n(rst_n), .bus(bus33)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic over the whole frame.
  function automatic void model(input int aw, output logic [63:0] s,
                                output logic [7:0] c, output bit o);
    longint unsigned t;
    t = 0;
    foreach (frame_q[i]) t += 64'(frame_q[i]);
    s = t & ((64'd1 << aw) - 64'd1);
    o = (t >> aw) != 0;
    c = (frame_q.size() > 255) ? 8'd255 : 8'(frame_q.size());
  endfunction

  // Called at a negedge with a beat driven; returns at the negedge after acceptance.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!bus40.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", bus40.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int max_gap);
    int g;
    foreach (frame_q[i]) begin
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_prod  = $urandom;
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_prod  = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_prod   = $urandom;
    in_last   = 1'b1;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus40.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus40.in_ready); end
    checks++; if (bus40.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus40.out_valid); end
    checks++; if (bus40.out_sum !== 40'd0) begin failures++; $display("FAIL reset_out_sum got=%0h exp=0", bus40.out_sum); end
    checks++; if (bus40.out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", bus40.out_count); end
    checks++; if (bus40.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%0b exp=0", bus40.out_ovf); end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++; if (bus40.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", bus40.in_ready); end
    checks++; if (bus40.out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_out_valid got=%0b exp=0", bus40.out_valid); end
  endtask

  task automatic test_three_beat();
    frame_q   = '{32'h6, 32'hC, 32'h1};
    out_ready = 1'b1;
    run_frame(0);
    checks++; if (bus40.out_valid !== 1'b1) begin failures++; $display("FAIL three_out_valid_rise got=%0b exp=1", bus40.out_valid); end
    checks++; if (bus40.out_sum !== 40'h13) begin failures++; $display("FAIL three_out_sum got=%0h exp=13", bus40.out_sum); end
    checks++; if (bus40.out_count !== 8'd3) begin failures++; $display("FAIL three_out_count got=%0d exp=3", bus40.out_count); end
    checks++; if (bus40.out_ovf !== 1'b0) begin failures++; $display("FAIL three_out_ovf got=%0b exp=0", bus40.out_ovf); end
    @(negedge clk);
    checks++; if (bus40.out_valid !== 1'b0) begin failures++; $display("FAIL three_out_valid_one_cycle got=%0b exp=0", bus40.out_valid); end
  endtask

  task automatic test_saturate();
    frame_q = {};
    repeat (256) frame_q.push_back(32'hFFFE0001);
    out_ready = 1'b1;
    run_frame(0);
    checks++; if (bus40.out_sum !== 40'hFFFE000100) begin failures++; $display("FAIL sat_out_sum got=%0h exp=fffe000100", bus40.out_sum); end
    checks++; if (bus40.out_count !== 8'hFF) begin failures++; $display("FAIL sat_out_count got=%0h exp=ff", bus40.out_count); end
    checks++; if (bus40.out_ovf !== 1'b0) begin failures++; $display("FAIL sat_out_ovf got=%0b exp=0", bus40.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    frame_q   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    out_ready = 1'b1;
    run_frame(0);
    checks++; if (bus33.out_sum !== 33'h0FFFFFFFD) begin failures++; $display("FAIL ovf33_out_sum got=%0h exp=0fffffffd", bus33.out_sum); end
    checks++; if (bus33.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf33_out_ovf got=%0b exp=1", bus33.out_ovf); end
    checks++; if (bus40.out_sum !== 40'h2FFFFFFFD) begin failures++; $display("FAIL ovf40_out_sum got=%0h exp=2fffffffd", bus40.out_sum); end
    checks++; if (bus40.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf40_out_ovf got=%0b exp=0", bus40.out_ovf); end
    frame_q = '{32'h5};
    run_frame(0);
    checks++; if (bus33.out_sum !== 33'h5) begin failures++; $display("FAIL ovf33_next_sum got=%0h exp=5", bus33.out_sum); end
    checks++; if (bus33.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf33_next_ovf_cleared got=%0b exp=0", bus33.out_ovf); end
    checks++; if (bus33.out_count !== 8'd1) begin failures++; $display("FAIL ovf33_next_count got=%0d exp=1", bus33.out_count); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [63:0] es;
    logic [7:0]  ec;
    bit          eo;
    logic [31:0] p;
    frame_q = {};
    repeat ($urandom_range(5, 2)) frame_q.push_back($urandom);
    model(40, es, ec, eo);
    out_ready = 1'b0;
    run_frame(2);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_prod  = $urandom;
      in_last  = 1'($urandom);
      checks++; if (bus40.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", k, bus40.in_ready); end
      checks++; if (bus40.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%0b exp=1", k, bus40.out_valid); end
      checks++; if (bus40.out_sum !== es[39:0]) begin failures++; $display("FAIL bp_out_sum cyc=%0d got=%0h exp=%0h", k, bus40.out_sum, es[39:0]); end
      checks++; if (bus40.out_count !== ec || bus40.out_ovf !== eo) begin failures++; $display("FAIL bp_count_ovf cyc=%0d got=%0d/%0b exp=%0d/%0b", k, bus40.out_count, bus40.out_ovf, ec, eo); end
      @(negedge clk);
    end
    p         = $urandom;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_prod   = p;
    in_last   = 1'b1;
    @(negedge clk);
    checks++; if (bus40.in_ready !== 1'b1 || bus40.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b/%0b exp=1/0", bus40.in_ready, bus40.out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (bus40.out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b exp=1", bus40.out_valid); end
    checks++; if (bus40.out_sum !== {8'd0, p} || bus40.out_count !== 8'd1) begin failures++; $display("FAIL bp_next_result got=%0h/%0d exp=%0h/1", bus40.out_sum, bus40.out_count, p); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    repeat (2) begin
      in_valid = 1'b1;
      in_prod  = $urandom;
      in_last  = 1'b0;
      wait_accept();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (bus40.out_valid !== 1'b0 || bus40.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%0b/%0b exp=0/0", bus40.out_valid, bus40.in_ready); end
    @(negedge clk);
    rst_n   = 1'b1;
    frame_q = '{32'h7};
    run_frame(0);
    checks++; if (bus40.out_sum !== 40'h7 || bus40.out_count !== 8'd1 || bus40.out_ovf !== 1'b0) begin failures++; $display("FAIL midrst_result got=%0h/%0d/%0b exp=7/1/0", bus40.out_sum, bus40.out_count, bus40.out_ovf); end
    @(negedge clk);
    out_ready = 1'b0;
    frame_q   = '{32'h1234_5678};
    run_frame(0);
    checks++; if (bus40.out_valid !== 1'b1) begin failures++; $display("FAIL heldrst_before got=%0b exp=1", bus40.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus40.out_valid !== 1'b0 || bus40.out_sum !== 40'd0) begin failures++; $display("FAIL heldrst_cleared got=%0b/%0h exp=0/0", bus40.out_valid, bus40.out_sum); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic [63:0] es40, es33;
    logic [7:0]  ec;
    bit          eo40, eo33;
    int          r;
    for (int f = 0; f < 20; f++) begin
      frame_q = {};
      repeat ($urandom_range(12, 1)) begin
        r = $urandom_range(5, 0);
        frame_q.push_back(r == 0 ? 32'h0 : (r == 1 ? 32'hFFFFFFFF : $urandom));
      end
      model(40, es40, ec, eo40);
      model(33, es33, ec, eo33);
      out_ready = 1'($urandom);
      run_frame(3);
      checks++; if (bus40.out_valid !== 1'b1) begin failures++; $display("FAIL rnd_valid f=%0d got=%0b exp=1", f, bus40.out_valid); end
      checks++; if (bus40.out_sum !== es40[39:0] || bus40.out_count !== ec || bus40.out_ovf !== eo40) begin failures++; $display("FAIL rnd_aw40 f=%0d got=%0h/%0d/%0b exp=%0h/%0d/%0b", f, bus40.out_sum, bus40.out_count, bus40.out_ovf, es40[39:0], ec, eo40); end
      checks++; if (bus33.out_sum !== es33[32:0] || bus33.out_count !== ec || bus33.out_ovf !== eo33) begin failures++; $display("FAIL rnd_aw33 f=%0d got=%0h/%0d/%0b exp=%0h/%0d/%0b", f, bus33.out_sum, bus33.out_count, bus33.out_ovf, es33[32:0], ec, eo33); end
      if (!out_ready) repeat ($urandom_range(4, 0)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus40.out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain f=%0d got=%0b exp=0", f, bus40.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_saturate();
    test_overflow();
    test_back_pressure();
    test_reset_mid();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
